header_insert: RTL and testbench

HEADER_INSERT -- requirements
Module: header_insert

---
 rtl/header_insert.sv | 200 ++++++++++++++++++++
 tb/tb_header_insert.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/header_insert.sv
// header_insert: prepends a 1..N byte header to a byte-packed payload stream.
// Latency: one cycle from payload handshake to output beat; one extra tail beat when the header pushes bytes past the last payload beat.
// Backpressure: ready_in follows the output register (free or draining); the output holds stable while valid_out && !ready_out.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   valid_in/ready_in, data_in, keep_in, last_in
//                                   payload stream (byte 0 in the MSBs, last keep left-aligned)
//   valid_insert/ready_insert, data_insert, keep_insert
//                                   header (valid bytes in the LSBs, keep right-aligned)
//   valid_out/ready_out, data_out, keep_out, last_out
//                                   merged stream, same byte order as the payload
//   err_keep                        sticky keep-pattern error, present only when
//                                   HEADER_INSERT_KEEP_CHECK_EN is defined
module header_insert #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef HEADER_INSERT_KEEP_CHECK_EN
  ,
  output logic                    err_keep
`endif
);

  // Byte counts run 0..N inclusive, so one bit wider than a byte index.
  localparam int LEN_WD = BYTE_CNT_WD + 1;
  localparam int SH_WD  = LEN_WD + 3;

  typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

  state_t                  state, state_nxt;
  logic [LEN_WD-1:0]       hdr_len;     // H, latched with the header
  logic [DATA_WD-1:0]      carry_dat;   // H bytes held back, right-aligned
  logic [DATA_BYTE_WD-1:0] carry_keep;

  logic                    out_free;
  logic                    hdr_fire, in_fire;
  logic                    load_stream, load_tail;
  logic [LEN_WD-1:0]       ins_len, rem_len;
  logic [SH_WD-1:0]        hdr_sh, rem_sh;
  logic [DATA_BYTE_WD-1:0] merge_keep, nxt_carry_keep, tail_keep;
  logic [DATA_WD-1:0]      merge_dat, nxt_carry_dat, tail_dat;
  logic                    need_tail;

  function automatic logic [LEN_WD-1:0] popcnt(input logic [DATA_BYTE_WD-1:0] k);
    logic [LEN_WD-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) c = c + LEN_WD'(k[i]);
    return c;
  endfunction

  // n ones in the low keep bits; n == N yields all ones.
  function automatic logic [DATA_BYTE_WD-1:0] low_keep(input logic [LEN_WD-1:0] n);
    return ~({DATA_BYTE_WD{1'b1}} << n);
  endfunction

  // keep bit i governs data bits [8i+7:8i].
  function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
    logic [DATA_WD-1:0] m;
    m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  // Datapath: carry goes to the top H byte lanes, the first N-H payload
  // bytes fill the rest, the last H payload bytes become the next carry.
  always_comb begin
    ins_len        = popcnt(keep_insert);
    rem_len        = LEN_WD'(DATA_BYTE_WD) - hdr_len;
    hdr_sh         = {hdr_len, 3'b000};
    rem_sh         = {rem_len, 3'b000};
    merge_keep     = (carry_keep << rem_len) | (keep_in >> hdr_len);
    merge_dat      = ((carry_dat << rem_sh) | (data_in >> hdr_sh)) & byte_mask(merge_keep);
    nxt_carry_keep = keep_in & low_keep(hdr_len);
    nxt_carry_dat  = data_in & byte_mask(nxt_carry_keep);
    // Any payload byte left in the carry after the last beat needs a tail beat.
    need_tail      = |nxt_carry_keep;
    tail_keep      = carry_keep << rem_len;
    tail_dat       = (carry_dat << rem_sh) & byte_mask(tail_keep);
  end

  // FSM next-state and handshakes
  always_comb begin
    state_nxt    = state;
    ready_in     = 1'b0;
    ready_insert = 1'b0;
    load_stream  = 1'b0;
    load_tail    = 1'b0;
    hdr_fire     = 1'b0;
    in_fire      = 1'b0;
    out_free     = !valid_out || ready_out;
    case (state)
      IDLE: begin
        ready_insert = 1'b1;
        if (valid_insert) begin
          hdr_fire  = 1'b1;
          state_nxt = STREAM;
        end
      end
      STREAM: begin
        ready_in = out_free;
        if (valid_in && out_free) begin
          in_fire     = 1'b1;
          load_stream = 1'b1;
          if (last_in) state_nxt = need_tail ? TAIL : IDLE;
        end
      end
      TAIL: begin
        if (out_free) begin
          load_tail = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_len    <= '0;
      carry_dat  <= '0;
      carry_keep <= '0;
      valid_out  <= 1'b0;
      data_out   <= '0;
      keep_out   <= '0;
      last_out   <= 1'b0;
    end else begin
      if (hdr_fire) begin
        hdr_len    <= ins_len;
        carry_dat  <= data_insert & byte_mask(low_keep(ins_len));
        carry_keep <= low_keep(ins_len);
      end else if (load_stream) begin
        carry_dat  <= nxt_carry_dat;
        carry_keep <= nxt_carry_keep;
      end else if (load_tail) begin
        carry_dat  <= '0;
        carry_keep <= '0;
      end

      if (load_stream) begin
        valid_out <= 1'b1;
        data_out  <= merge_dat;
        keep_out  <= merge_keep;
        last_out  <= last_in && !need_tail;
      end else if (load_tail) begin
        valid_out <= 1'b1;
        data_out  <= tail_dat;
        keep_out  <= tail_keep;
        last_out  <= 1'b1;
      end else if (ready_out) begin
        valid_out <= 1'b0;
      end
    end
  end

`ifdef HEADER_INSERT_KEEP_CHECK_EN
  logic [DATA_BYTE_WD-1:0] inv_keep;
  logic                    ins_bad, last_bad, mid_bad;

  // A mask is right-aligned contiguous iff k & (k+1) == 0; left-aligned iff
  // the same holds for its complement.
  always_comb begin
    inv_keep = ~keep_in;
    ins_bad  = (keep_insert == '0) ||
               ((keep_insert & (keep_insert + DATA_BYTE_WD'(1))) != '0);
    last_bad = (keep_in == '0) ||
               ((inv_keep & (inv_keep + DATA_BYTE_WD'(1))) != '0);
    mid_bad  = (keep_in != '1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_keep <= 1'b0;
    else if ((hdr_fire && ins_bad) || (in_fire && (last_in ? last_bad : mid_bad)))
      err_keep <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_header_insert.sv
// tb_header_insert: directed stimulus for header_insert (N=4) with a
// scoreboard queue filled at stimulus time and drained by a monitor.
// Ports: none (top-level bench).
module tb_header_insert;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
`ifdef HEADER_INSERT_KEEP_CHECK_EN
  logic        err_keep;
`endif

  typedef struct packed {
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    tests = 0;
  int    fails = 0;
  int    beat_idx = 0;
  int    stall_n;

  header_insert dut (
    .clk(clk), .rst(rst),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in),
    .last_in(last_in), .ready_in(ready_in),
    .valid_insert(valid_insert), .data_insert(data_insert),
    .keep_insert(keep_insert), .ready_insert(ready_insert),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out),
    .last_out(last_out), .ready_out(ready_out)
`ifdef HEADER_INSERT_KEEP_CHECK_EN
    , .err_keep(err_keep)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    beat_t b;
    b.dat = d; b.keep = k; b.last = l;
    exp_q.push_back(b);
  endtask

  // Monitor: a beat transfers at the posedge following a negedge where
  // valid_out && ready_out are both high.
  always @(negedge clk) begin
    if (!rst && valid_out && ready_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_beat: got %h/%b last=%b, expected no beat",
                 data_out, keep_out, last_out);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("out_beat%0d", beat_idx), {27'b0, data_out, keep_out, last_out},
              {27'b0, mon_e});
      end
      beat_idx++;
    end
  end

  task automatic send_hdr(input logic [31:0] d, input logic [3:0] k);
    int n;
    n = 0;
    valid_insert = 1'b1; data_insert = d; keep_insert = k;
    do begin @(negedge clk); n++; end while (!ready_insert && n < 50);
    if (!ready_insert) begin
      tests++; fails++;
      $display("FAIL hdr_timeout: ready_insert=%b, expected 1 within 50 cycles", ready_insert);
    end
    @(posedge clk); #1;
    valid_insert = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    do begin @(negedge clk); n++; end while (!ready_in && n < 50);
    if (!ready_in) begin
      tests++; fails++;
      $display("FAIL beat_timeout: ready_in=%b, expected 1 within 50 cycles", ready_in);
    end
    @(posedge clk); #1;
    valid_in = 1'b0; last_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_out) && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || valid_out) begin
      tests++; fails++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic pkt_a();
    push(32'hCCDD1122, 4'b1111, 1'b0);
    push(32'h33445566, 4'b1111, 1'b0);
    push(32'h77880000, 4'b1100, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    send_beat(32'h55667788, 4'b1111, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_out"},    {63'b0, valid_out},    64'd0);
    check({tag, "_last_out"},     {63'b0, last_out},     64'd0);
    check({tag, "_data_out"},     {32'b0, data_out},     64'd0);
    check({tag, "_keep_out"},     {60'b0, keep_out},     64'd0);
    check({tag, "_ready_in"},     {63'b0, ready_in},     64'd0);
    check({tag, "_ready_insert"}, {63'b0, ready_insert}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0;
    ready_out = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk); #1;

    // H=2, two full payload beats -> tail beat
    pkt_a();
    drain();

    // H=N: header alone, then payload via TAIL
    push(32'hAABBCCDD, 4'b1111, 1'b0);
    push(32'h11000000, 4'b1000, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b1111);
    send_beat(32'h11223344, 4'b1000, 1'b1);
    drain();

    // H=1, L=3 fits in one beat
    push(32'hEE112233, 4'b1111, 1'b1);
    send_hdr(32'h000000EE, 4'b0001);
    send_beat(32'h11223344, 4'b1110, 1'b1);
    drain();

    // Downstream stall mid-packet
    fork
      pkt_a();
      begin
        stall_n = 0;
        do begin @(negedge clk); stall_n++; end while (!valid_out && stall_n < 50);
        @(posedge clk); #1;
        ready_out = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check($sformatf("stall%0d_valid", i), {63'b0, valid_out}, 64'd1);
          check($sformatf("stall%0d_data", i),  {32'b0, data_out}, {32'b0, 32'h33445566});
          check($sformatf("stall%0d_keep", i),  {60'b0, keep_out}, 64'hF);
          check($sformatf("stall%0d_last", i),  {63'b0, last_out}, 64'd0);
          check($sformatf("stall%0d_ready_in", i), {63'b0, ready_in}, 64'd0);
        end
        @(posedge clk); #1;
        ready_out = 1'b1;
      end
    join
    drain();

    // Reset while the second payload beat is being offered
    send_hdr(32'hAABBCCDD, 4'b0011);
    send_beat(32'h11223344, 4'b1111, 1'b0);
    valid_in = 1'b1; data_in = 32'h55667788; keep_in = 4'b1111; last_in = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst1");
    valid_in = 1'b0; last_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pkt_a();
    drain();

`ifdef HEADER_INSERT_KEEP_CHECK_EN
    check("err_keep_clean", {63'b0, err_keep}, 64'd0);
    push(32'hCCDD1100, 4'b1110, 1'b0);
    push(32'h33000000, 4'b1000, 1'b1);
    send_hdr(32'hAABBCCDD, 4'b0011);
    check("err_keep_hdr_ok", {63'b0, err_keep}, 64'd0);
    send_beat(32'h11223344, 4'b1010, 1'b1);
    check("err_keep_set", {63'b0, err_keep}, 64'd1);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("err_keep_sticky", {63'b0, err_keep}, 64'd1);
    rst = 1'b1;
    #1;
    check("err_keep_rst", {63'b0, err_keep}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
